// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulator slice.
// The state encoding lives here so the top level and any bench share one definition.
package mac_pkg;

    localparam int DEF_IN_WIDTH  = 32;
    localparam int DEF_ACC_WIDTH = 48;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_out_clamp.sv
// Combinational output stage: narrows the accumulator to the result width.
// Build option MAC_ACCUMULATOR_SATURATE_EN selects clamping; otherwise the low bits wrap.
module acc_out_clamp
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] out_data
);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    // Sign-extend the output limits so the compare is done at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(OUT_MAX);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(OUT_MIN);

    always_comb begin
        if (acc > ACC_MAX) begin
            out_data = OUT_MAX;
        end else if (acc < ACC_MIN) begin
            out_data = OUT_MIN;
        end else begin
            out_data = acc[OUT_WIDTH-1:0];
        end
    end
`else
    // The upper accumulator bits are intentionally dropped in the wrapping build.
    logic unused_acc_bits;
    assign unused_acc_bits = ^acc;
    assign out_data        = acc[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums num_terms signed products into one result behind valid/ready handshakes.
// Output narrowing (wrap or MAC_ACCUMULATOR_SATURATE_EN clamp) is done in acc_out_clamp.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic        [CNT_WIDTH-1:0] num_terms,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    input  logic signed [IN_WIDTH-1:0]  prod_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                      state, state_nx;
    logic signed [ACC_WIDTH-1:0] acc, acc_nx;
    logic        [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic        [CNT_WIDTH-1:0] n, n_nx;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    assign prod_ext = ACC_WIDTH'(prod_data);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_nx   = state;
        acc_nx     = acc;
        cnt_nx     = cnt;
        n_nx       = n;
        prod_ready = 1'b0;
        out_valid  = 1'b0;

        case (state)
            IDLE: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    acc_nx   = prod_ext;
                    cnt_nx   = CNT_ONE;
                    n_nx     = num_terms;
                    // A count of zero behaves as a single-term result.
                    state_nx = (num_terms <= CNT_ONE) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    acc_nx = acc + prod_ext;
                    cnt_nx = cnt + CNT_ONE;
                    if (cnt_nx == n) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            n     <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            n     <= n_nx;
        end
    end

    acc_out_clamp #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_clamp (
        .acc      (acc),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a vector table of complete results plus
// hand-written sequences for stall, reset-abort and gapped-valid behaviour.
module tb_mac_accumulator;

    localparam int IN_WIDTH  = 32;
    localparam int ACC_WIDTH = 48;
    localparam int OUT_WIDTH = 16;
    localparam int CNT_WIDTH = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic        [CNT_WIDTH-1:0] num_terms;
    logic                        prod_valid;
    logic                        prod_ready;
    logic signed [IN_WIDTH-1:0]  prod_data;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        busy;

    int n_compared = 0;
    int n_failed   = 0;

    always #5 clk = ~clk;

    mac_accumulator #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .num_terms  (num_terms),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    typedef struct {
        string name;
        int    nt;
        int    cnt;
        int    p[4];
        int    exp_out;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents one product starting at a falling edge; returns at the falling edge after it transfers.
    task automatic push(input int v);
        int guard = 0;
        prod_valid = 1'b1;
        prod_data  = v;
        while (!prod_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            check("push_timeout", guard, 0);
        end
        @(negedge clk);
        prod_valid = 1'b0;
        prod_data  = '0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_valid"}, out_valid, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_ready"}, prod_ready, 1);
    endtask

    vec_t vecs[6];
    int   sat_pos;
    int   sat_neg;
    int   gap;

    initial begin
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        sat_pos = 32767;
        sat_neg = -32768;
`else
        sat_pos = -5536;
        sat_neg = 5536;
`endif
        vecs[0] = '{"three_terms", 3, 3, '{5, -2, 7, 0}, 10};
        vecs[1] = '{"zero_terms", 0, 1, '{-9, 0, 0, 0}, -9};
        vecs[2] = '{"one_term", 1, 1, '{1234, 0, 0, 0}, 1234};
        vecs[3] = '{"pos_overflow", 2, 2, '{30000, 30000, 0, 0}, sat_pos};
        vecs[4] = '{"four_neg", 4, 4, '{-100, -200, 50, -1}, -251};
        vecs[5] = '{"neg_overflow", 2, 2, '{-30000, -30000, 0, 0}, sat_neg};

        rst        = 1'b1;
        num_terms  = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", prod_ready, 1);
        check("post_rst_busy", busy, 0);

        foreach (vecs[i]) begin
            num_terms = CNT_WIDTH'(vecs[i].nt);
            for (int k = 0; k < vecs[i].cnt; k++) begin
                push(vecs[i].p[k]);
                if (k < vecs[i].cnt - 1) begin
                    check({vecs[i].name, "_early_valid"}, out_valid, 0);
                    check({vecs[i].name, "_accum_busy"}, busy, 1);
                end
            end
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check({vecs[i].name, "_data"}, out_data, vecs[i].exp_out);
            check({vecs[i].name, "_done_ready"}, prod_ready, 0);
            drain(vecs[i].name);
        end

        // Downstream stall: result must hold while a new product waits upstream.
        num_terms = 8'd1;
        push(42);
        prod_valid = 1'b1;
        prod_data  = 7;
        for (int c = 0; c < 4; c++) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 42);
            check("stall_ready", prod_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_release_valid", out_valid, 0);
        check("stall_release_ready", prod_ready, 1);
        @(negedge clk);
        prod_valid = 1'b0;
        check("stall_next_valid", out_valid, 1);
        check("stall_next_data", out_data, 7);
        drain("stall_next");

        // Reset in the middle of a four-term result discards the partial sum.
        num_terms = 8'd4;
        push(100);
        push(200);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", prod_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        num_terms = 8'd1;
        push(3);
        check("abort_new_valid", out_valid, 1);
        check("abort_new_data", out_data, 3);
        drain("abort_new");

        // Gapped valid and a num_terms change after the first product.
        num_terms = 8'd4;
        for (int k = 1; k <= 4; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                prod_data = 32'sd999;
                @(negedge clk);
                check("gap_valid", out_valid, 0);
            end
            push(k);
            if (k == 1) num_terms = 8'd2;
        end
        check("gap_result_valid", out_valid, 1);
        check("gap_result_data", out_data, 10);
        drain("gap_result");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of the signed product from the upstream multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 48: width of the internal signed accumulator; must be >= IN_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 16: width of the signed result.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: width of the term-count port; max terms = 2^CNT_WIDTH-1.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port num_terms, input, CNT_WIDTH: number of products per result, sampled only when the first product of a result is accepted.
REQ-008 SHALL have port prod_valid, input, 1: upstream product valid.
REQ-009 SHALL have port prod_ready, output, 1: block accepts a product this cycle.
REQ-010 SHALL have port prod_data, input, IN_WIDTH, signed: product from the multiplier.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_data, output, OUT_WIDTH, signed: accumulated result.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL transfer on either interface only in a cycle where valid and ready are both high.
REQ-016 SHALL implement three states: IDLE, ACCUM, DONE.
REQ-017 IDLE: prod_ready=1, out_valid=0; on a transfer, acc <= sign-extended prod_data, cnt <= 1, n <= num_terms; go to DONE if num_terms <= 1, else to ACCUM.
REQ-018 SHALL treat num_terms == 0 as 1.
REQ-019 ACCUM: prod_ready=1; on a transfer, acc <= acc + sign-extended prod_data and cnt <= cnt+1; go to DONE when cnt+1 == n; hold all state when prod_valid=0.
REQ-020 DONE: prod_ready=0, out_valid=1; out_data held stable while out_ready=0; on out_ready=1, go to IDLE.
REQ-021 SHALL assert out_valid in the cycle after the last product of a result is accepted (latency 1).
REQ-022 SHALL accept no product while in DONE; the minimum gap between results is one cycle.
REQ-023 SHALL never change out_data or out_valid while out_valid=1 and out_ready=0.
REQ-024 acc SHALL wrap modulo 2^ACC_WIDTH in two's complement on overflow.
REQ-025 SHALL ignore changes to num_terms after sampling until the next IDLE transfer.
REQ-026 SHALL drive prod_ready and out_valid combinationally from the state only, never from prod_valid or out_ready.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, acc=0, cnt=0, n=0; regardless of state, with any partial sum discarded.
REQ-028 During and after reset: out_valid=0, out_data=0, busy=0, prod_ready=1 from the first cycle after rst falls.

Configuration
REQ-029 Macro MAC_ACCUMULATOR_SATURATE_EN defined: out_data SHALL be acc clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-030 Macro absent: out_data SHALL be acc[OUT_WIDTH-1:0], truncated with wrap.

Structure
REQ-031 The state enum type and default width constants SHALL live in the shared package mac_pkg.
REQ-032 The saturate/truncate output stage SHALL be sub-module acc_out_clamp, combinational and parameterised by ACC_WIDTH and OUT_WIDTH.

Verification
REQ-033 num_terms=3, products 5, -2, 7 back-to-back, out_ready=1 -> out_valid one cycle after the third transfer, out_data=10, then IDLE.
REQ-034 num_terms=0, single product -9 -> treated as one term; out_data=-9 after 1 cycle.
REQ-035 out_ready=0 for 4 cycles in DONE -> out_data stable, prod_ready=0 throughout; the following product is accepted only after the result transfers.
REQ-036 num_terms=2, products 30000 and 30000, OUT_WIDTH=16 -> with the macro, out_data=32767; without it, out_data=-5536.
REQ-037 rst=1 asserted in ACCUM after 2 of 4 products -> next cycle IDLE, busy=0; a new 1-term result of 3 then yields out_data=3.
REQ-038 prod_valid toggled randomly with num_terms=4, products 1..4 -> out_data=10; num_terms changed mid-result has no effect.
